// File: rtl/servo_cmd_router.sv
// servo_cmd_router: joystick frame -> per-channel slew-limited servo pulse-width commands.
// Axis values are clamped, linearly mapped to microseconds with a centre deadband,
// routed to channels by AXIS_MAP, and each channel's command walks toward its target.
module servo_cmd_router #(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 10,
    parameter int CMD_W     = 12,
    parameter int IN_MIN    = 228,
    parameter int IN_MAX    = 830,
    parameter int US_MIN    = 650,
    parameter int US_MAX    = 2600,
    parameter int US_CENTER = 1500,
    parameter int DEADBAND  = 25,
    parameter int SLEW_STEP = 10,
    parameter int TICK_DIV  = 25000,
    parameter logic [NUM_CH-1:0] AXIS_MAP = 4'b1010
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    sample_valid,
    input  logic [IN_W-1:0]         x_pos,
    input  logic [IN_W-1:0]         y_pos,
    input  logic                    center_btn,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH*CMD_W-1:0] cmd,
    output logic [NUM_CH-1:0]       busy,
    output logic                    tick
);

    localparam int IN_SPAN = IN_MAX - IN_MIN;
    localparam int US_SPAN = US_MAX - US_MIN;
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [IN_W-1:0]  L_IN_MIN  = IN_W'(IN_MIN);
    localparam logic [IN_W-1:0]  L_IN_MAX  = IN_W'(IN_MAX);
    localparam logic [IN_W-1:0]  L_IN_SPAN = IN_W'(IN_SPAN);
    localparam logic [CMD_W-1:0] L_CENTER  = CMD_W'(US_CENTER);
    localparam logic [CMD_W-1:0] L_STEP    = CMD_W'(SLEW_STEP);
    localparam logic [CNT_W-1:0] L_CNT_TOP = CNT_W'(TICK_DIV - 1);
    localparam logic [31:0]      L_DB_LO   = 32'(US_CENTER - DEADBAND);
    localparam logic [31:0]      L_DB_HI   = 32'(US_CENTER + DEADBAND);

    // Clamp an axis reading into the usable range and return its offset from IN_MIN.
    function automatic logic [IN_W-1:0] f_clamp_off(input logic [IN_W-1:0] v);
        if (v < L_IN_MIN)      return '0;
        else if (v > L_IN_MAX) return L_IN_SPAN;
        else                   return v - L_IN_MIN;
    endfunction

    // Round-half-up linear map of an offset into microseconds, snapping the deadband to centre.
    // 32-bit arithmetic comfortably holds IN_SPAN*US_SPAN for any realistic servo range.
    function automatic logic [CMD_W-1:0] f_map(input logic [IN_W-1:0] off);
        logic [31:0] w_m;
        w_m = 32'(US_MIN) + (32'(off) * 32'(US_SPAN) + 32'(IN_SPAN / 2)) / 32'(IN_SPAN);
        if (w_m >= L_DB_LO && w_m <= L_DB_HI) w_m = 32'(US_CENTER);
        return w_m[CMD_W-1:0];
    endfunction

    // One slew step of at most L_STEP from c toward t.
    function automatic logic [CMD_W-1:0] f_slew(input logic [CMD_W-1:0] c, input logic [CMD_W-1:0] t);
        if (t > c) return ((t - c) <= L_STEP) ? t : c + L_STEP;
        else       return ((c - t) <= L_STEP) ? t : c - L_STEP;
    endfunction

    logic [IN_W-1:0]  r_s1_x;
    logic [IN_W-1:0]  r_s1_y;
    logic             r_s1_valid;
    logic             r_btn_prev;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [CMD_W-1:0] r_tgt [NUM_CH];
    logic [CMD_W-1:0] r_cmd [NUM_CH];

    logic [CMD_W-1:0] w_mx;
    logic [CMD_W-1:0] w_my;
    logic             w_recenter;
    logic             w_load;
    logic             w_tick;

    assign w_mx       = f_map(r_s1_x);
    assign w_my       = f_map(r_s1_y);
    assign w_recenter = sample_valid & center_btn & ~r_btn_prev;
    assign w_load     = r_s1_valid & ~r_btn_prev;
    assign w_tick     = (r_tick_cnt == L_CNT_TOP);
    assign tick       = w_tick;

    // Stage 1: capture clamped axis offsets and the sampled button level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_valid <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_s1_valid <= sample_valid;
            if (sample_valid) begin
                r_s1_x     <= f_clamp_off(x_pos);
                r_s1_y     <= f_clamp_off(y_pos);
                r_btn_prev <= center_btn;
            end
        end
    end

    // Free-running slew tick divider.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Stage 2: mapped values land directly in the target registers; recentre takes priority
    // and a held button blocks updates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_CH; i++) r_tgt[i] <= L_CENTER;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_en[i]) begin
                    if (w_recenter)  r_tgt[i] <= L_CENTER;
                    else if (w_load) r_tgt[i] <= AXIS_MAP[i] ? w_my : w_mx;
                end
            end
        end
    end

    // Command registers: follow targets directly when unlimited, otherwise step on each tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_CH; i++) r_cmd[i] <= L_CENTER;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (SLEW_STEP == 0) r_cmd[i] <= r_tgt[i];
                else if (w_tick)    r_cmd[i] <= f_slew(r_cmd[i], r_tgt[i]);
            end
        end
    end

    // Pack commands and flag channels still converging.
    always_comb begin
        cmd  = '0;
        busy = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cmd[i*CMD_W +: CMD_W] = r_cmd[i];
            busy[i]               = (r_cmd[i] != r_tgt[i]);
        end
    end

endmodule

// File: doc/servo_cmd_router.md
# servo_cmd_router

Parametrised joystick-to-servo command stage. Takes one sampled joystick frame (X, Y, buttons) plus per-channel enable switches, maps each axis linearly into a servo pulse width in microseconds, and maintains NUM_CH independent slew-limited pulse-width commands. Sits between the `joystick` SPI reader and the per-channel `servos` PWM generators in the arm controller top level. It replaces the fixed four-channel, unfiltered mapping with:
- configurable channel count and axis routing
- deadband around centre
- edge-triggered recentre
- per-tick slew limiting

## Interface
Parameters:
- NUM_CH, 4: number of servo channels.
- IN_W, 10: joystick axis width.
- CMD_W, 12: command width (µs).
- IN_MIN, 228 / IN_MAX, 830: usable axis range.
- US_MIN, 650 / US_MAX, 2600 / US_CENTER, 1500: pulse-width limits and centre (µs).
- DEADBAND, 25: mapped values within ±DEADBAND of US_CENTER snap to US_CENTER.
- SLEW_STEP, 10: maximum command change per tick (µs). 0 disables limiting.
- TICK_DIV, 25000: CLK cycles per slew tick (1 ms at 25 MHz).
- AXIS_MAP, 4'b1010: bit i=0 routes X to channel i, bit i=1 routes Y.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; x_pos/y_pos/center_btn valid.
- x_pos  in  IN_W  joystick X.
- y_pos  in  IN_W  joystick Y.
- center_btn  in  1  recentre button, level, already synchronous to CLK.
- ch_en  in  NUM_CH  per-channel enable (board switches).
- cmd  out  NUM_CH*CMD_W  packed commands; channel i at [i*CMD_W +: CMD_W].
- busy  out  NUM_CH  bit i high while cmd_i != target_i.
- tick  out  1  one-cycle slew tick strobe.

## Operation
- Reset: all target_i = cmd_i = US_CENTER, busy = 0, tick = 0, tick counter = 0, pipeline valids = 0, button history = 0.
- Mapping, per axis:
  - c = clamp(v, IN_MIN, IN_MAX).
  - m = US_MIN + ((c−IN_MIN)*(US_MAX−US_MIN) + (IN_MAX−IN_MIN)/2) / (IN_MAX−IN_MIN), integer floor division, i.e. round-half-up.
  - If |m−US_CENTER| ≤ DEADBAND, m = US_CENTER.
  - Intermediate product width must hold (IN_MAX−IN_MIN)*(US_MAX−US_MIN) without overflow.
- Pipeline: stage 1 registers clamped/offset X and Y; stage 2 registers mapped mx, my and a valid bit.
- Target update, when the stage-2 valid is set: each channel with ch_en[i]=1 loads target_i = (AXIS_MAP[i] ? my : mx). Disabled channels hold their target.
- Recentre:
  - A rising edge of center_btn, sampled only on cycles with sample_valid (previous sampled value kept in a register), sets target_i = US_CENTER for every enabled channel.
  - While the sampled center_btn stays high, stage-2 target updates are suppressed for enabled channels.
- Slew:
  - tick pulses for one cycle when the counter reaches TICK_DIV−1; the counter then wraps to 0.
  - On tick: d = target_i − cmd_i. If |d| ≤ SLEW_STEP, cmd_i = target_i; otherwise cmd_i moves by SLEW_STEP toward target_i.
  - If SLEW_STEP = 0: cmd_i = target_i every cycle, registered, independent of tick.
- Disabling a channel mid-slew does not stop it; cmd keeps converging to the frozen target.
- cmd always stays within [US_MIN, US_MAX]; US_CENTER is also a legal value.

## Timing
- sample_valid at cycle t: stage-1 register at t+1, target at t+2.
- cmd first moves on the first tick at or after t+3 (t+3 exactly when SLEW_STEP = 0).
- Recentre edge sampled at t: target = US_CENTER at t+1.
- Simultaneous events:
  - Recentre and a stage-2 update in the same cycle: recentre wins for enabled channels.
  - Tick and target change in the same cycle: the slew step uses the old target.
- busy_i is combinational from registered cmd_i and target_i.
- A sample_valid arriving every cycle is accepted; the pipeline is fully pipelined with no backpressure.
- Reset asserted mid-slew or mid-pipeline: all state returns to reset values immediately. The first sample after release follows normal latency.

## Test plan
- Reset, then ch_en=4'b0001, SLEW_STEP=0, sample x=830: cmd0=2600 at t+3. Channels 1–3 stay at 1500; busy=0 afterwards.
- Clamp and rounding, SLEW_STEP=0, ch_en=4'b1111:
  - x=100, y=1000 → ch0=ch2=650, ch1=ch3=2600.
  - x=529 → ch0=1625.
- Deadband: x=490 (raw 1499) → ch0=1500. x=300 (raw 883) → ch0=883.
- Slew at defaults, ch0 enabled, x=830 from 1500: cmd0 rises 10 µs per tick and reaches 2600 on tick 110. busy0 high throughout and falls in the same cycle cmd0 hits 2600.
- Recentre: ch_en=4'b0011 at 2600/2600. center_btn 0→1 on a sample → both targets 1500 next cycle. Further samples with the button held do not change targets; releasing the button and sampling y=228 → ch1 target 650.
- Mid-slew reset: assert RST_N low during a 1500→2600 slew → cmd=1500, busy=0, tick counter 0 immediately.
